baud_rate_gen: RTL and testbench
================================

Name: baud_rate_gen

Overview:
- Programmable baud-rate generator for the SPART serial port.
- Holds a 16-bit divisor written by the processor over the shared databus, at ioaddr 2'b10 (low byte) and 2'b11 (high byte).
- Emits a one-clock enable pulse once per bit period.
- The enable output feeds the enable input of the receive buffer directly, and also feeds the transmit buffer; both treat one enable pulse as one serial bit time.

Parameters:
- DEFAULT_DIVISOR, 16'd5207, divisor loaded at reset (50 MHz clk, 9600 baud); 0 means generator stopped.
- WIDTH, 16, divisor/counter width; fixed at 16 (two byte writes).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- iocs  input  1  chip select for SPART I/O space
- iorw  input  1  1 = processor read, 0 = processor write
- ioaddr  input  2  register select; this block decodes only 2'b10 and 2'b11
- databus  inout  8  shared bidirectional bus; input for divisor writes, driven only per Optional Feature
- enable  output  1  one-cycle baud tick to receive/transmit buffers

Behaviour:
- Reset: and rst is asynchronous, active-high; clock clk.
  - divisor = DEFAULT_DIVISOR; low-byte staging reg db_low = DEFAULT_DIVISOR[7:0]; counter = DEFAULT_DIVISOR; enable = 0.
  - state = RUN if DEFAULT_DIVISOR != 0, else STOP.
- Write decode: wr_lo = iocs & ~iorw & (ioaddr == 2'b10); wr_hi = iocs & ~iorw & (ioaddr == 2'b11).
  - Other ioaddr values are ignored (they belong to the receive/transmit buffers and status).
- Low write: db_low <= databus. Divisor and counter are unchanged, so the current rate keeps running.
- High write (commit): divisor <= {databus, db_low}; counter <= {databus, db_low}; enable <= 0 that cycle.
  - If the new divisor == 0, go to STOP; else go to RUN.
  - Software must write low then high. A high write alone commits with the previous db_low.
- States:
  - STOP: counter held, enable held 0. Leave only on a commit of a nonzero divisor.
  - RUN: if counter == 0 then enable <= 1 and counter <= divisor; else enable <= 0 and counter <= counter - 1.
- Period: enable pulses every divisor+1 clk cycles and is high exactly one cycle.
  - First pulse: registered (divisor+1) cycles after reset release or after a commit.
- Divisor 1 gives a period of 2 (enable alternates). There is no case where enable is high for two consecutive cycles.
- Simultaneous events: a commit in the same cycle the counter hits 0 takes priority. The counter loads the new divisor and enable stays 0.
- Counter arithmetic is unsigned 16-bit. Decrement never wraps because the zero case always reloads.
- Reset mid-period: asynchronous return to reset values. Any pending db_low value is lost.
- databus is never driven by this block for writes. With the feature disabled it is always high-Z.

Optional Feature:
- Macro: BAUD_DIVISOR_READBACK_EN.
- Defined:
  - When iocs & iorw and ioaddr == 2'b10, drive databus with divisor[7:0].
  - When iocs & iorw and ioaddr == 2'b11, drive divisor[15:8].
  - Drive is combinational, same cycle. High-Z otherwise. No conflict with the receive buffer, which drives only ioaddr 2'b00.
- Undefined: databus permanently high-Z from this block; reads of 2'b10/2'b11 return whatever the bus floats to.

Test Plan:
- Reset, DEFAULT_DIVISOR = 5207:
  - Release rst, count cycles.
  - Expected: first enable 5208 cycles after release, then every 5208 cycles; each pulse exactly 1 cycle wide.
- Program divisor 3:
  - Stimulus: write 8'h03 to ioaddr 10, then 8'h00 to ioaddr 11.
  - Expected: enable at cycles 4, 8, 12 after the commit cycle; low write alone leaves the old period unchanged.
- Stop and restart:
  - Stimulus: write 8'h00 to ioaddr 10 and to ioaddr 11; hold 100 cycles.
  - Expected: enable never asserts and the counter is frozen.
  - Then write 8'h01 to ioaddr 10 and 8'h00 to ioaddr 11. Expected: enable toggles 0/1 every cycle.
- Commit collides with terminal count:
  - Stimulus: with divisor 3, issue the ioaddr 11 write in the cycle counter == 0, new divisor 8'h05.
  - Expected: no enable that cycle; next enable 6 cycles later.
- Decode isolation plus async reset:
  - Stimulus: writes to ioaddr 00/01 and writes with iocs = 0.
  - Expected: period unchanged.
  - Stimulus: assert rst mid-period. Expected: enable drops to 0 immediately and the counter reloads 5207.
- Readback (BAUD_DIVISOR_READBACK_EN defined):
  - Stimulus: after programming 16'h1457, read ioaddr 10 then 11.
  - Expected: databus = 8'h57, then 8'h14.
  - With the macro undefined, databus stays z.

Source files
------------

// File: rtl/baud_rate_gen.sv
// baud_rate_gen -- programmable baud-rate generator for the SPART serial port.
//
// A 16-bit divisor is written by the processor as two bytes over the shared
// databus (ioaddr 2'b10 = low byte, staged; ioaddr 2'b11 = high byte, commits).
// While running, 'enable' pulses high for one clk cycle every divisor+1 cycles;
// a divisor of 0 stops the generator.
//
// Optional feature (macro BAUD_DIVISOR_READBACK_EN):
//   defined   -> processor reads of ioaddr 2'b10/2'b11 return the divisor
//                low/high byte, driven combinationally onto databus.
//   undefined -> databus is never driven by this block (always high-Z).
//
// Ports:
//   clk      in     system clock
//   rst      in     asynchronous, active-high reset
//   iocs     in     chip select for SPART I/O space
//   iorw     in     1 = processor read, 0 = processor write
//   ioaddr   in     register select (only 2'b10 and 2'b11 decoded here)
//   databus  inout  shared 8-bit bidirectional bus
//   enable   out    one-cycle baud tick to receive/transmit buffers

module baud_rate_gen #(
  parameter int unsigned           WIDTH           = 16,
  parameter logic [WIDTH-1:0]      DEFAULT_DIVISOR = 16'd5207
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  logic [7:0] databus,
  output logic       enable
);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   counter;
  logic [7:0]         db_low;

  logic               wr_lo;
  logic               wr_hi;
  logic [WIDTH-1:0]   new_divisor;

  always_comb begin
    wr_lo       = iocs & ~iorw & (ioaddr == 2'b10);
    wr_hi       = iocs & ~iorw & (ioaddr == 2'b11);
    new_divisor = {databus, db_low};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor <= DEFAULT_DIVISOR;
      db_low  <= DEFAULT_DIVISOR[7:0];
      counter <= DEFAULT_DIVISOR;
      enable  <= 1'b0;
      state   <= (DEFAULT_DIVISOR != '0) ? RUN : STOP;
    end else begin
      if (wr_lo) begin
        db_low <= databus;
      end

      // A commit outranks the terminal count: the reload wins and the tick
      // that would have fired this cycle is suppressed.
      if (wr_hi) begin
        divisor <= new_divisor;
        counter <= new_divisor;
        enable  <= 1'b0;
        state   <= (new_divisor != '0) ? RUN : STOP;
      end else begin
        case (state)
          STOP: begin
            enable <= 1'b0;
          end
          RUN: begin
            if (counter == '0) begin
              enable  <= 1'b1;
              counter <= divisor;
            end else begin
              enable  <= 1'b0;
              counter <= counter - WIDTH'(1);
            end
          end
          default: begin
            enable <= 1'b0;
            state  <= STOP;
          end
        endcase
      end
    end
  end

`ifdef BAUD_DIVISOR_READBACK_EN
  logic rd_lo;
  logic rd_hi;

  always_comb begin
    rd_lo = iocs & iorw & (ioaddr == 2'b10);
    rd_hi = iocs & iorw & (ioaddr == 2'b11);
  end

  assign databus = rd_lo ? divisor[7:0] :
                   rd_hi ? divisor[15:8] : 8'bz;
`else
  assign databus = 8'bz;
`endif

endmodule

// File: tb/tb_baud_rate_gen.sv
module tb_baud_rate_gen;

  localparam logic [15:0] DEF = 16'd5207;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       iocs   = 1'b0;
  logic       iorw   = 1'b1;
  logic [1:0] ioaddr = 2'b00;
  logic       enable;

  logic       tb_drive = 1'b1;
  logic [7:0] tb_data  = 8'h00;
  wire  [7:0] databus;

  assign databus = tb_drive ? tb_data : 8'bz;

  baud_rate_gen #(
    .WIDTH(16),
    .DEFAULT_DIVISOR(DEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .iocs(iocs),
    .iorw(iorw),
    .ioaddr(ioaddr),
    .databus(databus),
    .enable(enable)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a tick is due divisor+1 edges after the last reload
  // event (reset, commit or previous tick); divisor 0 means no ticks.
  bit          exp_q[$];
  longint      cyc     = 1;   // index of the next rising edge
  longint      anchor  = 0;   // edge index of the last reload event
  logic [15:0] m_div   = DEF;
  logic [7:0]  m_low   = DEF[7:0];
  bit          last_exp = 1'b0;
  logic        rst_req = 1'b1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of bus activity at the falling edge and queue the value
  // enable must take after the following rising edge.
  task automatic cycle(input bit cs, input bit rw, input logic [1:0] a, input logic [7:0] d);
    bit e;
    bit wlo, whi;
    @(negedge clk);
    rst    = rst_req;
    iocs   = cs;
    iorw   = rw;
    ioaddr = a;
    tb_data = d;
`ifdef BAUD_DIVISOR_READBACK_EN
    tb_drive = !(cs && rw && a[1]);
`else
    tb_drive = 1'b1;
`endif
    e = 1'b0;
    if (rst_req) begin
      m_div  = DEF;
      m_low  = DEF[7:0];
      anchor = cyc;
    end else begin
      wlo = cs && !rw && (a == 2'b10);
      whi = cs && !rw && (a == 2'b11);
      if (whi) begin
        m_div  = {d, m_low};
        anchor = cyc;
      end else if (m_div != 16'd0 && cyc == anchor + longint'(m_div) + 1) begin
        e      = 1'b1;
        anchor = cyc;
      end
      if (wlo) m_low = d;
    end
    exp_q.push_back(e);
    last_exp = e;
    cyc++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b1, 2'b00, 8'h00);
  endtask

  // Random bus traffic; with allow_prog = 0 only traffic that must not
  // disturb the generator is produced.
  task automatic rand_cycle(input bit allow_prog);
    int r;
    r = $urandom_range(0, 99);
    if (allow_prog && r < 3)
      cycle(1'b1, 1'b0, 2'b10, 8'($urandom_range(0, 40)));
    else if (allow_prog && r < 5)
      cycle(1'b1, 1'b0, 2'b11, 8'h00);
    else if (r >= 5 && r < 12)
      cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom));
    else if (r >= 12 && r < 18)
      cycle(1'b1, 1'b0, 2'($urandom_range(0, 1)), 8'($urandom));
    else if (r >= 18 && r < 22)
      cycle(1'b1, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
    else
      idle();
  endtask

  task automatic read_check(input string name, input logic [1:0] a);
    logic [7:0] float_val;
    logic [7:0] exp;
    float_val = 8'($urandom);
    cycle(1'b1, 1'b1, a, float_val);
    #1;
`ifdef BAUD_DIVISOR_READBACK_EN
    exp = a[0] ? m_div[15:8] : m_div[7:0];
`else
    exp = float_val;
`endif
    check8(name, databus, exp);
  endtask

  // Monitor: pops the expected value after every rising edge.
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_bit("enable", enable, e);
      end
    end
  end

  initial begin
    int guard;

    repeat (3) idle();
    #1;
    check_bit("reset_enable", enable, 1'b0);

    // Default rate with harmless traffic and one low-byte-only write.
    rst_req = 1'b0;
    for (int i = 0; i < 2 * 5208 + 20; i++) begin
      if (i == 3000) cycle(1'b1, 1'b0, 2'b10, 8'h22);
      else rand_cycle(1'b0);
    end

    // Divisor 3.
    cycle(1'b1, 1'b0, 2'b10, 8'h03);
    cycle(1'b1, 1'b0, 2'b11, 8'h00);
    repeat (20) idle();

    // Stop, then restart with divisor 1.
    cycle(1'b1, 1'b0, 2'b10, 8'h00);
    cycle(1'b1, 1'b0, 2'b11, 8'h00);
    repeat (100) idle();
    cycle(1'b1, 1'b0, 2'b10, 8'h01);
    cycle(1'b1, 1'b0, 2'b11, 8'h00);
    repeat (10) idle();

    // Commit landing on the terminal count.
    cycle(1'b1, 1'b0, 2'b10, 8'h03);
    cycle(1'b1, 1'b0, 2'b11, 8'h00);
    idle();
    cycle(1'b1, 1'b0, 2'b10, 8'h05);
    guard = 0;
    while (!(cyc == anchor + longint'(m_div) + 1) && guard < 20) begin
      idle();
      guard++;
    end
    check_bit("collision_setup", bit'(guard < 20), 1'b1);
    cycle(1'b1, 1'b0, 2'b11, 8'h00);
    repeat (15) idle();

    // Randomised programming and traffic.
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);

    // Readback of 16'h1457.
    cycle(1'b1, 1'b0, 2'b10, 8'h57);
    cycle(1'b1, 1'b0, 2'b11, 8'h14);
    read_check("readback_lo", 2'b10);
    read_check("readback_hi", 2'b11);
    repeat (5) idle();

    // Asynchronous reset while enable is high.
    cycle(1'b1, 1'b0, 2'b10, 8'h03);
    cycle(1'b1, 1'b0, 2'b11, 8'h00);
    guard = 0;
    while (!last_exp && guard < 20) begin
      idle();
      guard++;
    end
    check_bit("pulse_before_reset", last_exp, 1'b1);
    @(posedge clk);
    #2;
    check_bit("enable_high_pre_reset", enable, 1'b1);
    rst_req = 1'b1;
    rst = 1'b1;
    #1;
    check_bit("async_reset_drop", enable, 1'b0);
    repeat (3) idle();
    rst_req = 1'b0;
    repeat (5208 + 10) idle();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
